kf8259_inta_sequencer: RTL and testbench



---
 rtl/kf8259_inta_pkg.sv | 19 +
 rtl/kf8259_inta_sequencer.sv | 145 ++++++++++++++
 tb/tb_kf8259_inta_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/kf8259_inta_pkg.sv
// Shared types and constants for the INTA# acknowledge sequencer.
package kf8259_inta_pkg;

    // Sequencer states, walked strictly in order for one acknowledge cycle.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INTA1 = 3'd1,
        GAP   = 3'd2,
        INTA2 = 3'd3,
        VALID = 3'd4
    } inta_state_t;

    // Vector handed to the core when the PIC fails to drive the bus.
    localparam logic [7:0] SPURIOUS_VECTOR = 8'hFF;

    localparam int unsigned DEFAULT_PULSE_CYCLES = 4;
    localparam int unsigned DEFAULT_GAP_CYCLES   = 2;

endpackage

// File: rtl/kf8259_inta_sequencer.sv
// CPU-side two-pulse INTA# sequencer: freezes the PIC, captures the vector
// byte on the second pulse and offers it to the core via valid/ack.
module kf8259_inta_sequencer
    import kf8259_inta_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = DEFAULT_PULSE_CYCLES,
    parameter int unsigned GAP_CYCLES   = DEFAULT_GAP_CYCLES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       interrupt_to_cpu,
    input  logic       interrupt_enable,
    output logic       interrupt_pending,
    input  logic       int_accept,
    output logic       interrupt_acknowledge_n,
    output logic       bus_lock,
    input  logic [7:0] pic_data,
    input  logic       pic_data_io,
    output logic [7:0] vector,
    output logic       vector_valid,
    output logic       vector_error,
    input  logic       vector_ack
);

    localparam int unsigned MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

    inta_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inta_n_q, inta_n_d;
    logic             lock_q, lock_d;
    logic [7:0]       vector_q, vector_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;
    logic             cnt_zero;

    // Only an enabled request seen while idle may start a sequence.
    assign interrupt_pending = interrupt_to_cpu & interrupt_enable & (state_q == IDLE);

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        inta_n_d = inta_n_q;
        lock_d   = lock_q;
        vector_d = vector_q;
        valid_d  = valid_q;
        error_d  = error_q;
        cnt_zero = (cnt_q == '0);

        case (state_q)
            IDLE: begin
                if (int_accept && interrupt_pending) begin
                    state_d  = INTA1;
                    cnt_d    = PULSE_LOAD;
                    inta_n_d = 1'b0;
                    lock_d   = 1'b1;
                end
            end
            INTA1: begin
                if (cnt_zero) begin
                    state_d  = GAP;
                    cnt_d    = GAP_LOAD;
                    inta_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    state_d  = INTA2;
                    cnt_d    = PULSE_LOAD;
                    inta_n_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            INTA2: begin
                if (cnt_zero) begin
                    // Last cycle of pulse 2: the PIC's byte is settled now.
                    state_d  = VALID;
                    cnt_d    = '0;
                    inta_n_d = 1'b1;
                    lock_d   = 1'b0;
                    valid_d  = 1'b1;
                    if (!pic_data_io) begin
                        vector_d = pic_data;
                        error_d  = 1'b0;
                    end else begin
                        vector_d = SPURIOUS_VECTOR;
                        error_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            VALID: begin
                if (vector_ack) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    error_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                inta_n_d = 1'b1;
                lock_d   = 1'b0;
                valid_d  = 1'b0;
                error_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            inta_n_q <= 1'b1;
            lock_q   <= 1'b0;
            vector_q <= 8'h00;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            inta_n_q <= inta_n_d;
            lock_q   <= lock_d;
            vector_q <= vector_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    assign interrupt_acknowledge_n = inta_n_q;
    assign bus_lock                = lock_q;
    assign vector                  = vector_q;
    assign vector_valid            = valid_q;
    assign vector_error            = error_q;

endmodule

// File: tb/tb_kf8259_inta_sequencer.sv
// Directed bench: default-timing instance (a) and a P=2/G=1 instance (b)
// share all inputs; each table row names which instance it checks.
module tb_kf8259_inta_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       intr = 1'b1;
    logic       ien = 1'b1;
    logic       acc = 1'b0;
    logic [7:0] data = 8'h00;
    logic       io = 1'b1;
    logic       ack = 1'b0;

    logic       pend_a, inta_a, lock_a, val_a, err_a;
    logic [7:0] vec_a;
    logic       pend_b, inta_b, lock_b, val_b, err_b;
    logic [7:0] vec_b;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    kf8259_inta_sequencer dut_a (
        .clock(clk), .reset(rst), .interrupt_to_cpu(intr), .interrupt_enable(ien),
        .interrupt_pending(pend_a), .int_accept(acc), .interrupt_acknowledge_n(inta_a),
        .bus_lock(lock_a), .pic_data(data), .pic_data_io(io), .vector(vec_a),
        .vector_valid(val_a), .vector_error(err_a), .vector_ack(ack)
    );

    kf8259_inta_sequencer #(.PULSE_CYCLES(2), .GAP_CYCLES(1)) dut_b (
        .clock(clk), .reset(rst), .interrupt_to_cpu(intr), .interrupt_enable(ien),
        .interrupt_pending(pend_b), .int_accept(acc), .interrupt_acknowledge_n(inta_b),
        .bus_lock(lock_b), .pic_data(data), .pic_data_io(io), .vector(vec_b),
        .vector_valid(val_b), .vector_error(err_b), .vector_ack(ack)
    );

    typedef struct {
        logic       sel;
        logic       chk;
        logic       rst;
        logic       intr;
        logic       ien;
        logic       acc;
        logic [7:0] data;
        logic       io;
        logic       ack;
        logic       e_inta;
        logic       e_lock;
        logic       e_val;
        logic [7:0] e_vec;
        logic       e_err;
    } row_t;

    row_t tbl[$];

    task automatic add(input int n, input logic sel, chk, r, it, ie, ac,
                       input logic [7:0] d, input logic dio, ak, e_inta, e_lock, e_val,
                       input logic [7:0] e_vec, input logic e_err);
        row_t x;
        x.sel = sel; x.chk = chk; x.rst = r; x.intr = it; x.ien = ie; x.acc = ac;
        x.data = d; x.io = dio; x.ack = ak;
        x.e_inta = e_inta; x.e_lock = e_lock; x.e_val = e_val; x.e_vec = e_vec; x.e_err = e_err;
        repeat (n) tbl.push_back(x);
    endtask

    task automatic add_rst(input logic sel);
        add(1, sel, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Scenario A: defaults, PIC drives 0A; stray accept and ack are ignored.
        add_rst(0);
        add(1, 0,1,0,1,1,1, 8'h00,1,0, 1,0,0,8'h00,0);  // c0 accept
        add(1, 0,1,0,1,1,0, 8'h00,1,0, 0,1,0,8'h00,0);  // c1
        add(1, 0,1,0,1,1,1, 8'h00,1,0, 0,1,0,8'h00,0);  // c2 accept mid-pulse
        add(2, 0,1,0,1,1,0, 8'h00,1,0, 0,1,0,8'h00,0);  // c3-4
        add(2, 0,1,0,1,1,0, 8'h00,1,0, 1,1,0,8'h00,0);  // c5-6 gap
        add(2, 0,1,0,1,1,0, 8'h0A,0,0, 0,1,0,8'h00,0);  // c7-8
        add(1, 0,1,0,1,1,0, 8'h0A,0,1, 0,1,0,8'h00,0);  // c9 ack outside VALID
        add(1, 0,1,0,1,1,0, 8'h0A,0,0, 0,1,0,8'h00,0);  // c10 sample point
        add(2, 0,1,0,1,1,0, 8'h00,1,0, 1,0,1,8'h0A,0);  // c11-12
        add(1, 0,1,0,1,1,0, 8'h00,1,1, 1,0,1,8'h0A,0);  // c13 ack
        add(1, 0,1,0,1,1,0, 8'h00,1,0, 1,0,0,8'h00,0);  // c14
        // Scenario B: PIC never drives -> spurious vector with error.
        add_rst(0);
        add(1, 0,1,0,1,1,1, 8'h00,1,0, 1,0,0,8'h00,0);
        add(4, 0,1,0,1,1,0, 8'h00,1,0, 0,1,0,8'h00,0);
        add(2, 0,1,0,1,1,0, 8'h00,1,0, 1,1,0,8'h00,0);
        add(4, 0,1,0,1,1,0, 8'h0A,1,0, 0,1,0,8'h00,0);
        add(1, 0,1,0,1,1,0, 8'h00,1,1, 1,0,1,8'hFF,1);  // c11
        add(1, 0,1,0,1,1,0, 8'h00,1,0, 1,0,0,8'h00,0);
        // Scenario D: INTR drops at cycle 5, sequence completes, 0F captured.
        add_rst(0);
        add(1, 0,1,0,1,1,1, 8'h00,1,0, 1,0,0,8'h00,0);
        add(4, 0,1,0,1,1,0, 8'h00,1,0, 0,1,0,8'h00,0);
        add(2, 0,1,0,0,1,0, 8'h00,1,0, 1,1,0,8'h00,0);
        add(4, 0,1,0,0,1,0, 8'h0F,0,0, 0,1,0,8'h00,0);
        add(1, 0,1,0,0,1,0, 8'h00,1,1, 1,0,1,8'h0F,0);
        add(1, 0,1,0,0,1,0, 8'h00,1,0, 1,0,0,8'h00,0);
        // Scenario E: reset at cycle 8, restart accepted at cycle 10.
        add_rst(0);
        add(1, 0,1,0,1,1,1, 8'h00,1,0, 1,0,0,8'h00,0);  // c0
        add(4, 0,1,0,1,1,0, 8'h00,1,0, 0,1,0,8'h00,0);  // c1-4
        add(2, 0,1,0,1,1,0, 8'h00,1,0, 1,1,0,8'h00,0);  // c5-6
        add(1, 0,1,0,1,1,0, 8'h00,1,0, 0,1,0,8'h00,0);  // c7
        add(1, 0,1,1,1,1,0, 8'h00,1,0, 0,1,0,8'h00,0);  // c8 reset
        add(1, 0,1,0,1,1,0, 8'h00,1,0, 1,0,0,8'h00,0);  // c9
        add(1, 0,1,0,1,1,1, 8'h00,1,0, 1,0,0,8'h00,0);  // c10 accept
        add(4, 0,1,0,1,1,0, 8'h00,1,0, 0,1,0,8'h00,0);  // c11-14
        add(2, 0,1,0,1,1,0, 8'h00,1,0, 1,1,0,8'h00,0);  // c15-16
        add(4, 0,1,0,1,1,0, 8'h33,0,0, 0,1,0,8'h00,0);  // c17-20
        add(1, 0,1,0,1,1,0, 8'h00,1,1, 1,0,1,8'h33,0);  // c21
        add(1, 0,1,0,1,1,0, 8'h00,1,0, 1,0,0,8'h00,0);  // c22
        // Scenario F: P=2, G=1; accept in ack cycle ignored, next one taken.
        add_rst(1);
        add(1, 1,1,0,1,1,1, 8'h00,1,0, 1,0,0,8'h00,0);  // c0
        add(2, 1,1,0,1,1,0, 8'h00,1,0, 0,1,0,8'h00,0);  // c1-2
        add(1, 1,1,0,1,1,0, 8'h00,1,0, 1,1,0,8'h00,0);  // c3
        add(2, 1,1,0,1,1,0, 8'h21,0,0, 0,1,0,8'h00,0);  // c4-5
        add(1, 1,1,0,1,1,1, 8'h00,1,1, 1,0,1,8'h21,0);  // c6 ack + accept
        add(1, 1,1,0,1,1,1, 8'h00,1,0, 1,0,0,8'h00,0);  // c7 accept
        add(2, 1,1,0,1,1,0, 8'h00,1,0, 0,1,0,8'h00,0);  // c8-9
        add(1, 1,1,0,1,1,0, 8'h00,1,0, 1,1,0,8'h00,0);  // c10

        // Reset values of both instances.
        rst = 1'b1;
        cyc();
        check("rst_inta_a", 0, 32'(inta_a), 32'd1);
        check("rst_lock_a", 0, 32'(lock_a), 32'd0);
        check("rst_vec_a",  0, 32'(vec_a),  32'h00);
        check("rst_val_a",  0, 32'(val_a),  32'd0);
        check("rst_err_a",  0, 32'(err_a),  32'd0);
        check("rst_inta_b", 0, 32'(inta_b), 32'd1);
        check("rst_val_b",  0, 32'(val_b),  32'd0);
        rst = 1'b0;

        // Table run: check outputs for this cycle, then drive this cycle's inputs.
        foreach (tbl[i]) begin
            cyc();
            if (tbl[i].chk) begin
                check("inta_n", i, 32'(tbl[i].sel ? inta_b : inta_a), 32'(tbl[i].e_inta));
                check("lock",   i, 32'(tbl[i].sel ? lock_b : lock_a), 32'(tbl[i].e_lock));
                check("valid",  i, 32'(tbl[i].sel ? val_b  : val_a),  32'(tbl[i].e_val));
                if (tbl[i].e_val) begin
                    check("vector", i, 32'(tbl[i].sel ? vec_b : vec_a), 32'(tbl[i].e_vec));
                    check("error",  i, 32'(tbl[i].sel ? err_b : err_a), 32'(tbl[i].e_err));
                end
            end
            rst  = tbl[i].rst;
            intr = tbl[i].intr;
            ien  = tbl[i].ien;
            acc  = tbl[i].acc;
            data = tbl[i].data;
            io   = tbl[i].io;
            ack  = tbl[i].ack;
        end

        // Latency and back-to-back turnaround on the default instance.
        cyc();
        rst = 1'b1; acc = 1'b0; ack = 1'b0; intr = 1'b1; ien = 1'b1; io = 1'b1;
        cyc();
        rst = 1'b0; acc = 1'b1;
        begin
            int n;
            logic got;
            n = 0;
            got = 1'b0;
            while (!got && n < 40) begin
                cyc();
                acc = 1'b0;
                n++;
                got = val_a;
            end
            check("valid_latency", 0, 32'(n), 32'd11);
        end
        check("spurious_err", 0, 32'(err_a), 32'd1);
        ack = 1'b1; acc = 1'b1;
        cyc();
        ack = 1'b0;
        check("post_ack_valid",   0, 32'(val_a),  32'd0);
        check("post_ack_inta",    0, 32'(inta_a), 32'd1);
        check("post_ack_pending", 0, 32'(pend_a), 32'd1);
        cyc();
        acc = 1'b0;
        check("b2b_inta",    0, 32'(inta_a), 32'd0);
        check("b2b_pending", 0, 32'(pend_a), 32'd0);

        // Interrupts disabled: accept pulse must not start anything.
        rst = 1'b1;
        cyc();
        rst = 1'b0; ien = 1'b0; acc = 1'b1; io = 1'b0; data = 8'h55;
        cyc();
        acc = 1'b0;
        check("dis_pending", 0, 32'(pend_a), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            check("dis_inta",  k, 32'(inta_a), 32'd1);
            check("dis_valid", k, 32'(val_a),  32'd0);
            cyc();
        end
        ien = 1'b1;
        #1;
        check("idle_pending", 0, 32'(pend_a), 32'd1);
        intr = 1'b0;
        #1;
        check("no_intr_pending", 0, 32'(pend_a), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
